// File: rtl/instruction_encoder.sv
// Purpose : encodes one symbolic MIPS operation per handshake and writes the word(s) to instruction memory.
// Latency : a word accepted at edge k is presented on o_MemWrite/o_Addr_32/o_Data_32 from the cycle after k.
// Backpressure: o_Ready drops while a write is pending or memory is full; writes stall until in_MemAck.
//
// Ports:
//   clk, reset                 single rising-edge clock, asynchronous active-low reset
//   in_Valid / o_Ready         operation handshake
//   in_Op_4                    0 R,1 ADDI,2 ORI,3 ANDI,4 LUI,5 BEQ,6 BNE,7 LW,8 SW,9 J,10 JAL,11 LI
//   in_Rs_5..in_Funct_6        register, shift and function fields
//   in_Imm_32                  immediate ([15:0] I-type, [25:0] jump target, all 32 bits for LI)
//   in_Clear                   synchronous clear of address/count, overrides everything
//   o_MemWrite/o_Addr_32/o_Data_32/in_MemAck   instruction-memory write port
//   o_Full, o_Error, o_Count_11                status
//
// Build option: define INSTR_ENCODER_PSEUDO_LI_EN to make op 11 (LI) a legal two-word
// LUI/ORI expansion. Without it, op 11 is rejected like any other illegal opcode.

module instruction_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_Valid,
    output logic        o_Ready,
    input  logic [3:0]  in_Op_4,
    input  logic [4:0]  in_Rs_5,
    input  logic [4:0]  in_Rt_5,
    input  logic [4:0]  in_Rd_5,
    input  logic [4:0]  in_Shamt_5,
    input  logic [5:0]  in_Funct_6,
    input  logic [31:0] in_Imm_32,
    input  logic        in_Clear,
    output logic        o_MemWrite,
    output logic [31:0] o_Addr_32,
    output logic [31:0] o_Data_32,
    input  logic        in_MemAck,
    output logic        o_Full,
    output logic        o_Error,
    output logic [10:0] o_Count_11
);

    // ------------------------------------------------------------------
    // Operation selector values
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_ORI  = 4'd2;
    localparam logic [3:0] OP_ANDI = 4'd3;
    localparam logic [3:0] OP_LUI  = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;
    localparam logic [3:0] OP_JAL  = 4'd10;
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
    localparam logic [3:0] OP_LI   = 4'd11;
`endif

    // ------------------------------------------------------------------
    // MIPS primary opcodes
    // ------------------------------------------------------------------
    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_ORI  = 6'h0D;
    localparam logic [5:0] OPC_ANDI = 6'h0C;
    localparam logic [5:0] OPC_LUI  = 6'h0F;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_BNE  = 6'h05;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_JAL  = 6'h03;

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
    // LI needs two free slots: legal while count <= DEPTH-2.
    localparam logic [10:0] LI_LIMIT = 11'(DEPTH - 2);
`endif

    // ------------------------------------------------------------------
    // FSM state
    // ------------------------------------------------------------------
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE1 = 2'd1,
        WRITE2 = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE1 = 2'd1
    } state_t;
`endif

    state_t      state;
    logic [31:0] addr;
    logic [31:0] data;
    logic [10:0] count;
    logic        error;

`ifdef INSTR_ENCODER_PSEUDO_LI_EN
    logic [31:0] data2;      // second word of an LI, moved into data after the first ack
    logic        two_words;  // current write sequence is an LI pair
`endif

    // ------------------------------------------------------------------
    // Instruction word builders
    // ------------------------------------------------------------------
    function automatic logic [31:0] itype(input logic [5:0]  op,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0]  op,
                                          input logic [25:0] target);
        return {op, target};
    endfunction

    // ------------------------------------------------------------------
    // Combinational encode of the operation currently offered
    // ------------------------------------------------------------------
    logic [31:0] enc_w0;
    logic [31:0] enc_w1;
    logic        enc_legal;
    logic        enc_two;

    always_comb begin
        enc_w0    = '0;
        enc_w1    = '0;
        enc_legal = 1'b1;
        enc_two   = 1'b0;
        case (in_Op_4)
            OP_R:    enc_w0 = {OPC_R, in_Rs_5, in_Rt_5, in_Rd_5, in_Shamt_5, in_Funct_6};
            OP_ADDI: enc_w0 = itype(OPC_ADDI, in_Rs_5, in_Rt_5, in_Imm_32[15:0]);
            OP_ORI:  enc_w0 = itype(OPC_ORI,  in_Rs_5, in_Rt_5, in_Imm_32[15:0]);
            OP_ANDI: enc_w0 = itype(OPC_ANDI, in_Rs_5, in_Rt_5, in_Imm_32[15:0]);
            // LUI has no source register; the rs field is always zero.
            OP_LUI:  enc_w0 = itype(OPC_LUI,  5'd0,    in_Rt_5, in_Imm_32[15:0]);
            OP_BEQ:  enc_w0 = itype(OPC_BEQ,  in_Rs_5, in_Rt_5, in_Imm_32[15:0]);
            OP_BNE:  enc_w0 = itype(OPC_BNE,  in_Rs_5, in_Rt_5, in_Imm_32[15:0]);
            OP_LW:   enc_w0 = itype(OPC_LW,   in_Rs_5, in_Rt_5, in_Imm_32[15:0]);
            OP_SW:   enc_w0 = itype(OPC_SW,   in_Rs_5, in_Rt_5, in_Imm_32[15:0]);
            OP_J:    enc_w0 = jtype(OPC_J,   in_Imm_32[25:0]);
            OP_JAL:  enc_w0 = jtype(OPC_JAL, in_Imm_32[25:0]);
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
            OP_LI: begin
                // LUI rt, hi16 ; ORI rt, rt, lo16
                enc_w0    = itype(OPC_LUI, 5'd0,    in_Rt_5, in_Imm_32[31:16]);
                enc_w1    = itype(OPC_ORI, in_Rt_5, in_Rt_5, in_Imm_32[15:0]);
                enc_two   = 1'b1;
                // Never start a pair that cannot complete; a half-written LI
                // would leave the register with only the upper half loaded.
                enc_legal = (count <= LI_LIMIT);
            end
`endif
            default: enc_legal = 1'b0;
        endcase
    end

`ifndef INSTR_ENCODER_PSEUDO_LI_EN
    // Without LI the top immediate bits never reach an instruction word.
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_Imm_32[31:26];
`endif

    // ------------------------------------------------------------------
    // Status / handshake
    // ------------------------------------------------------------------
    assign o_Full     = (count == DEPTH_W);
    assign o_Ready    = (state == IDLE) && !o_Full;
    assign o_MemWrite = (state != IDLE);
    assign o_Addr_32  = addr;
    assign o_Data_32  = data;
    assign o_Count_11 = count;
    assign o_Error    = error;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            addr  <= BASE_ADDR;
            data  <= '0;
            count <= '0;
            error <= 1'b0;
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
            data2     <= '0;
            two_words <= 1'b0;
`endif
        end else begin
            error <= 1'b0;
            if (in_Clear) begin
                // Clear wins over accepts and acks alike; a write in flight
                // is dropped even if memory acknowledges it this cycle.
                state <= IDLE;
                addr  <= BASE_ADDR;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_Valid && o_Ready) begin
                            if (enc_legal) begin
                                data  <= enc_w0;
                                state <= WRITE1;
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
                                data2     <= enc_w1;
                                two_words <= enc_two;
`endif
                            end else begin
                                // Rejected: consume the request, flag it, stay idle.
                                error <= 1'b1;
                            end
                        end
                    end
                    WRITE1: begin
                        if (in_MemAck) begin
                            addr  <= addr + 32'd4;
                            count <= count + 11'd1;
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
                            if (two_words) begin
                                data  <= data2;
                                state <= WRITE2;
                            end else begin
                                state <= IDLE;
                            end
`else
                            state <= IDLE;
`endif
                        end
                    end
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
                    WRITE2: begin
                        if (in_MemAck) begin
                            addr      <= addr + 32'd4;
                            count     <= count + 11'd1;
                            two_words <= 1'b0;
                            state     <= IDLE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_Valid;
    logic        o_Ready;
    logic [3:0]  in_Op_4;
    logic [4:0]  in_Rs_5, in_Rt_5, in_Rd_5, in_Shamt_5;
    logic [5:0]  in_Funct_6;
    logic [31:0] in_Imm_32;
    logic        in_Clear;
    logic        o_MemWrite;
    logic [31:0] o_Addr_32, o_Data_32;
    logic        in_MemAck;
    logic        o_Full, o_Error;
    logic [10:0] o_Count_11;

    int errors = 0;
    int checks = 0;
    int m_count = 0;
    logic [31:0] last_data [2];
    logic [31:0] last_addr [2];

    instruction_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_Valid(in_Valid), .o_Ready(o_Ready),
        .in_Op_4(in_Op_4), .in_Rs_5(in_Rs_5), .in_Rt_5(in_Rt_5), .in_Rd_5(in_Rd_5),
        .in_Shamt_5(in_Shamt_5), .in_Funct_6(in_Funct_6), .in_Imm_32(in_Imm_32),
        .in_Clear(in_Clear),
        .o_MemWrite(o_MemWrite), .o_Addr_32(o_Addr_32), .o_Data_32(o_Data_32),
        .in_MemAck(in_MemAck),
        .o_Full(o_Full), .o_Error(o_Error), .o_Count_11(o_Count_11)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish expected finish before 400000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: instruction words from field arithmetic.
    // Returns the number of words to be written, 0 when the operation is rejected.
    function automatic int model_words(input int op, input int rs, input int rt, input int rd,
                                       input int sh, input int fn, input logic [31:0] imm,
                                       output logic [31:0] w0, output logic [31:0] w1);
        longint opc_tab [11] = '{0, 8, 13, 12, 15, 4, 5, 35, 43, 2, 3};
        longint im = longint'(imm);
        longint f  = 64'd1 << 26;
        w0 = '0;
        w1 = '0;
        if (op == 0) begin
            w0 = 32'(longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
                     + longint'(sh) * 64 + longint'(fn));
            return 1;
        end
        if (op >= 1 && op <= 8) begin
            longint s = (op == 4) ? 0 : longint'(rs);
            w0 = 32'(opc_tab[op] * f + s * 2097152 + longint'(rt) * 65536 + (im % 65536));
            return 1;
        end
        if (op == 9 || op == 10) begin
            w0 = 32'(opc_tab[op] * f + (im % f));
            return 1;
        end
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
        if (op == 11) begin
            if (DEPTH - m_count < 2) return 0;
            w0 = 32'(15 * f + longint'(rt) * 65536 + (im / 65536));
            w1 = 32'(13 * f + longint'(rt) * 2097152 + longint'(rt) * 65536 + (im % 65536));
            return 2;
        end
`endif
        return 0;
    endfunction

    // Offer one operation (model expects o_Ready), follow it through to idle.
    // stall = ack-low cycles before each word's ack; stall 0 also holds ack high during accept.
    task automatic issue(input int op, input int rs, input int rt, input int rd, input int sh,
                         input int fn, input logic [31:0] imm, input int stall);
        logic [31:0] w [2];
        int n;
        n = model_words(op, rs, rt, rd, sh, fn, imm, w[0], w[1]);
        check("ready_before", 32'(o_Ready), 32'(m_count != DEPTH));
        in_Op_4 = 4'(op); in_Rs_5 = 5'(rs); in_Rt_5 = 5'(rt); in_Rd_5 = 5'(rd);
        in_Shamt_5 = 5'(sh); in_Funct_6 = 6'(fn); in_Imm_32 = imm;
        in_Valid = 1'b1;
        in_MemAck = (stall == 0);
        cycle();
        in_Valid = 1'b0;
        if (n == 0) begin
            check("err_pulse", 32'(o_Error), 32'd1);
            check("err_no_write", 32'(o_MemWrite), 32'd0);
            check("err_count", 32'(o_Count_11), 32'(m_count));
            in_MemAck = 1'b0;
            cycle();
            check("err_one_cycle", 32'(o_Error), 32'd0);
            check("err_ready_after", 32'(o_Ready), 32'(m_count != DEPTH));
        end else begin
            for (int i = 0; i < n; i++) begin
                last_data[i] = o_Data_32;
                last_addr[i] = o_Addr_32;
                for (int s = 0; s <= stall; s++) begin
                    check("wr_memwrite", 32'(o_MemWrite), 32'd1);
                    check("wr_addr", o_Addr_32, BASE + 32'(4 * m_count));
                    check("wr_data", o_Data_32, w[i]);
                    check("wr_ready_low", 32'(o_Ready), 32'd0);
                    in_MemAck = (s == stall);
                    cycle();
                end
                m_count++;
                check("wr_count", 32'(o_Count_11), 32'(m_count));
            end
            in_MemAck = 1'b0;
            check("done_idle", 32'(o_MemWrite), 32'd0);
            check("done_full", 32'(o_Full), 32'(m_count == DEPTH));
            check("done_ready", 32'(o_Ready), 32'(m_count != DEPTH));
            check("done_error", 32'(o_Error), 32'd0);
        end
    endtask

    task automatic do_clear();
        in_Clear = 1'b1;
        cycle();
        in_Clear = 1'b0;
        m_count = 0;
        check("clr_addr", o_Addr_32, BASE);
        check("clr_count", 32'(o_Count_11), 32'd0);
        check("clr_ready", 32'(o_Ready), 32'd1);
        check("clr_full", 32'(o_Full), 32'd0);
        check("clr_memwrite", 32'(o_MemWrite), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        in_Valid = 1'b0; in_Op_4 = '0; in_Rs_5 = '0; in_Rt_5 = '0; in_Rd_5 = '0;
        in_Shamt_5 = '0; in_Funct_6 = '0; in_Imm_32 = '0; in_Clear = 1'b0; in_MemAck = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();

        // Reset state
        check("rst_addr", o_Addr_32, BASE);
        check("rst_data", o_Data_32, 32'd0);
        check("rst_count", 32'(o_Count_11), 32'd0);
        check("rst_memwrite", 32'(o_MemWrite), 32'd0);
        check("rst_error", 32'(o_Error), 32'd0);
        check("rst_full", 32'(o_Full), 32'd0);
        check("rst_ready", 32'(o_Ready), 32'd1);

        // ADDI $8, $0, 5
        issue(1, 0, 8, 0, 0, 0, 32'd5, 0);
        check("addi_word", last_data[0], 32'h2008_0005);
        check("addi_addr", last_addr[0], 32'h0040_0000);
        check("addi_count", 32'(o_Count_11), 32'd1);

        // add $10, $8, $9
        issue(0, 8, 9, 10, 0, 32'h20, 32'd0, 1);
        check("radd_word", last_data[0], 32'h0109_5020);
        check("radd_addr", last_addr[0], 32'h0040_0004);

        // LI with 3-cycle ack stalls (needs two free slots: count 0 after clear)
        do_clear();
        issue(11, 0, 8, 0, 0, 0, 32'h1234_5678, 3);
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
        check("li_word1", last_data[0], 32'h3C08_1234);
        check("li_word2", last_data[1], 32'h3508_5678);
        check("li_addr2", last_addr[1], 32'h0040_0004);
`endif

        // Full, LI reject near full, clear
        do_clear();
        for (int i = 0; i < 3; i++) begin
            issue(9, 0, 0, 0, 0, 0, 32'h0010_0000, 0);
            check("j_word", last_data[0], 32'h0810_0000);
        end
        issue(11, 0, 8, 0, 0, 0, 32'h1234_5678, 0);
        check("li_reject_count", 32'(o_Count_11), 32'd3);
        issue(9, 0, 0, 0, 0, 0, 32'h0010_0000, 0);
        check("full_flag", 32'(o_Full), 32'd1);
        check("full_ready", 32'(o_Ready), 32'd0);
        in_Op_4 = 4'd9; in_Valid = 1'b1; in_MemAck = 1'b1;
        cycle();
        in_Valid = 1'b0; in_MemAck = 1'b0;
        check("full_no_accept", 32'(o_MemWrite), 32'd0);
        check("full_no_error", 32'(o_Error), 32'd0);
        check("full_count_hold", 32'(o_Count_11), 32'd4);
        do_clear();

        // Illegal opcode
        issue(14, 1, 2, 3, 4, 5, 32'hFFFF_FFFF, 0);
        check("illegal_count", 32'(o_Count_11), 32'd0);

        // Clear during a write, with an ack in the same cycle
        issue(2, 3, 4, 0, 0, 0, 32'h0000_ABCD, 0);
        in_Op_4 = 4'd1; in_Rs_5 = 5'd1; in_Rt_5 = 5'd2; in_Imm_32 = 32'd7;
        in_Valid = 1'b1; in_MemAck = 1'b0;
        cycle();
        in_Valid = 1'b0;
        check("clrw_pending", 32'(o_MemWrite), 32'd1);
        in_Clear = 1'b1; in_MemAck = 1'b1;
        cycle();
        in_Clear = 1'b0; in_MemAck = 1'b0;
        m_count = 0;
        check("clrw_memwrite", 32'(o_MemWrite), 32'd0);
        check("clrw_count", 32'(o_Count_11), 32'd0);
        check("clrw_addr", o_Addr_32, BASE);

        // Asynchronous reset in the middle of a write sequence
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
        in_Op_4 = 4'd11; in_Rt_5 = 5'd3; in_Imm_32 = 32'hCAFE_BEEF;
        in_Valid = 1'b1; in_MemAck = 1'b1;
        cycle();
        in_Valid = 1'b0;
        cycle();
        check("rstw_in_write2", 32'(o_MemWrite), 32'd1);
        check("rstw_count1", 32'(o_Count_11), 32'd1);
        check("rstw_word2", o_Data_32, 32'h3463_BEEF);
`else
        in_Op_4 = 4'd1; in_Rt_5 = 5'd3; in_Imm_32 = 32'h0000_BEEF;
        in_Valid = 1'b1; in_MemAck = 1'b0;
        cycle();
        in_Valid = 1'b0;
        check("rstw_in_write1", 32'(o_MemWrite), 32'd1);
`endif
        #2 reset = 1'b0;
        #1;
        check("rstw_memwrite", 32'(o_MemWrite), 32'd0);
        check("rstw_count", 32'(o_Count_11), 32'd0);
        check("rstw_addr", o_Addr_32, BASE);
        in_MemAck = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_count = 0;
        cycle();
        check("rstw_ready", 32'(o_Ready), 32'd1);

        // Randomized operations against the model
        for (int k = 0; k < 40; k++) begin
            if (m_count == DEPTH || $urandom_range(0, 7) == 0) do_clear();
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                  $urandom, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Instruction encoder and loader for the MIPS processor: the encode-side counterpart of the opcode decoder. It accepts one symbolic operation per handshake, assembles the 32-bit MIPS instruction word(s), and writes them sequentially into instruction memory starting at a base address. Test benches and the boot path use it to fill program memory.

## Interface
- `BASE_ADDR`, default 32'h0040_0000: byte address of the first word written.
- `DEPTH`, default 64: capacity in words (range 2..1024). The address wraps only via `in_Clear`, never by overflow.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low. The polarity and synchronicity are fixed.
- `in_Valid` input 1: operation request.
- `o_Ready` output 1: encoder can accept an operation.
- `in_Op_4` input 4: operation selector.
  - 0 R-type, 1 ADDI, 2 ORI, 3 ANDI, 4 LUI, 5 BEQ, 6 BNE, 7 LW, 8 SW, 9 J, 10 JAL, 11 LI (pseudo).
  - 12–15 are illegal.
- `in_Rs_5`, `in_Rt_5`, `in_Rd_5`, `in_Shamt_5` input 5 each: register and shift fields.
- `in_Funct_6` input 6: R-type function code.
- `in_Imm_32` input 32: immediate. `[15:0]` is used by I-type operations, the full 32 bits by LI, and `[25:0]` is the jump target.
- `in_Clear` input 1: synchronous clear of the address and word count.
- `o_MemWrite` output 1: instruction-memory write request.
- `o_Addr_32` output 32: byte address of the write.
- `o_Data_32` output 32: instruction word.
- `in_MemAck` input 1: memory accepted the current write.
- `o_Full` output 1: word count equals `DEPTH`.
- `o_Error` output 1: one-cycle pulse on a rejected operation.
- `o_Count_11` output 11: number of words written.

## Operation
- **Opcodes:** R=6'h00, ADDI=08, ORI=0D, ANDI=0C, LUI=0F, BEQ=04, BNE=05, LW=23, SW=2B, J=02, JAL=03.
- **Encodings:**
  - R-type: {6'h00, rs, rt, rd, shamt, funct}.
  - I-type: {op, rs, rt, imm[15:0]}. LUI forces rs=0.
  - J-type: {op, imm[25:0]}.
- **LI** expands to two words:
  - word 1: LUI rt, imm[31:16];
  - word 2: ORI rt, rt, imm[15:0].
- **FSM states:** IDLE, WRITE1, WRITE2.
  - IDLE → WRITE1 on accept (`in_Valid && o_Ready`) of a legal operation. The encoded word(s) are registered at this point.
  - WRITE1 → IDLE on `in_MemAck`. For LI, WRITE1 → WRITE2 on `in_MemAck` instead.
  - WRITE2 → IDLE on `in_MemAck`.
- **Ready:** `o_Ready` = (state==IDLE) && !`o_Full`.
- **Write request:** `o_MemWrite` = state ∈ {WRITE1, WRITE2}.
- **Write side:** while `o_MemWrite` is high, `o_Addr_32` and `o_Data_32` hold stable until the acknowledging edge. Each ack increments the address by 4 and the count by 1.
- **Illegal operation:** op 12–15, or LI with fewer than 2 free words. It is accepted in IDLE and discarded. `o_Error` pulses high the next cycle, nothing is written, and the FSM stays in IDLE.
- **`in_Clear`:**
  - has priority over every other event in any state;
  - address returns to `BASE_ADDR`, count to 0, state to IDLE;
  - any in-flight write is abandoned and an ack in the same cycle is ignored.
- **Full:** when count==`DEPTH`, `o_Full`=1 and no further operations are accepted until `in_Clear`.
- **Reset values:** state IDLE, `o_Addr_32`=`BASE_ADDR`, `o_Data_32`=0, count 0, and `o_MemWrite`, `o_Error`, `o_Full` all 0. `o_Ready`=1.
- **Reset mid-write** aborts immediately with no further write.

## Timing
- An operation accepted at edge k drives `o_MemWrite` from the cycle after edge k.
- Single-word write with ack held high: accepted at edge k, written at edge k+1, `o_Ready` high again after edge k+1. Throughput is 1 word per 2 cycles.
- LI with ack held high: words are written at edges k+1 and k+2, and the FSM is back in IDLE after edge k+2.
- `o_Error` is registered: high for exactly the cycle after the rejecting accept.
- `o_Full` and `o_Count_11` update at the same edge as the ack that wrote the word.

## Configuration
- `INSTR_ENCODER_PSEUDO_LI_EN` defined: op 11 is legal and expands to the LUI/ORI pair, and the WRITE2 state exists.
- Macro undefined: op 11 is illegal (pulses `o_Error`), and WRITE2 and the free-slot check are not compiled.

## Test plan
- **ADDI:** rs=0, rt=8, imm=5, ack held high → one write, addr 0x00400000, data 0x20080005, count 1.
- **R-type add:** rs=8, rt=9, rd=10, shamt=0, funct=0x20 → data 0x01095020 at the next address, 0x00400004.
- **LI with ack stalled:** LI rt=8, imm=0x12345678, ack low 3 cycles before each word → data 0x3C081234 then 0x35085678. Address, data and `o_MemWrite` stay stable during the stalls, and `o_Ready` stays low until the second ack.
- **Full, LI reject and clear** (`DEPTH`=4):
  - three J ops with imm=0x0100000 → each word is 0x08100000;
  - a following LI → `o_Error` pulse, count stays 3;
  - one more J → `o_Full`=1, `o_Ready`=0;
  - `in_Clear` → addr 0x00400000, count 0, `o_Ready`=1.
- **Illegal op:** op=14 → `o_Error` one cycle, no `o_MemWrite`, state stays IDLE.
- **Async reset during WRITE2 of an LI** → `o_MemWrite` drops immediately, and count and address return to their reset values.
